lcd_id_detect: RTL and testbench

//  Reads the LCD panel strap ID from the MSB pins of the RGB bus after reset, before the LCD

---
 rtl/lcd_id_detect_if.sv | 31 +++
 rtl/lcd_id_detect.sv | 156 +++++++++++++++
 tb/tb_lcd_id_detect.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_id_detect_if.sv
// Bus between the RGB pad strap inputs, the ID detector and the LCD driver logic.
// slave : seen from the detector (strap pins and redetect in, ID results out)
// master: seen from the surrounding logic / testbench
interface lcd_id_detect_if #(
  parameter int RGB_W = 24
);
  logic [RGB_W-1:0] i_lcd_rgb_in;
  logic             i_redetect;
  logic             o_lcd_rgb_oe;
  logic [15:0]      o_id_lcd;
  logic             o_id_valid;
  logic             o_id_err;

  modport slave (
    input  i_lcd_rgb_in,
    input  i_redetect,
    output o_lcd_rgb_oe,
    output o_id_lcd,
    output o_id_valid,
    output o_id_err
  );

  modport master (
    output i_lcd_rgb_in,
    output i_redetect,
    input  o_lcd_rgb_oe,
    input  o_id_lcd,
    input  o_id_valid,
    input  o_id_err
  );
endinterface

// File: rtl/lcd_id_detect.sv
// LCD panel strap ID detector.
// Reads the MSB of each RGB byte lane while the pads are tristated, after a settle delay,
// requiring SAMPLES consecutive agreeing samples, with bounded retries and a software
// re-detect request. Falls back to DEFAULT_ID and flags id_err if no attempt agrees.
// Optional macro LCD_ID_SYNC_EN: pass the strap vector through a 2-flop synchroniser.
module lcd_id_detect #(
  parameter int          RGB_W      = 24,
  parameter int          ID_BITS    = 3,
  parameter int          SETTLE_CYC = 1000,
  parameter int          SAMPLES    = 4,
  parameter int          MAX_RETRY  = 3,
  parameter logic [15:0] DEFAULT_ID = 16'd5
) (
  input logic             clk,
  input logic             rst_n,
  lcd_id_detect_if.slave  bus
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int SW = $clog2(SAMPLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SMP_LAST   = SW'(SAMPLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [SW-1:0]        r_scnt;
  logic [RW-1:0]        r_retry;
  logic [ID_BITS-1:0]   r_ref;
  logic                 r_mismatch;
  logic [15:0]          r_id_lcd;
  logic                 r_id_valid;
  logic                 r_id_err;
  logic                 r_lcd_rgb_oe;
  logic [ID_BITS-1:0]   w_pins;
  logic [ID_BITS-1:0]   w_p;

  // Gather the MSB of each byte lane into the strap vector, lane 0 in bit 0
  always_comb begin
    w_pins = '0;
    for (int k = 0; k < ID_BITS; k++) begin
      w_pins[k] = bus.i_lcd_rgb_in[8*k+7];
    end
  end

`ifdef LCD_ID_SYNC_EN
  logic [ID_BITS-1:0] r_sync1;
  logic [ID_BITS-1:0] r_sync2;

  // Two-flop synchroniser for straps arriving from asynchronous pads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = r_sync2;
`else
  assign w_p = w_pins;
`endif

  // Detection FSM: settle, sample and compare, evaluate/retry, then hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SETTLE;
      r_cnt        <= '0;
      r_scnt       <= '0;
      r_retry      <= '0;
      r_ref        <= '0;
      r_mismatch   <= 1'b0;
      r_id_lcd     <= DEFAULT_ID;
      r_id_valid   <= 1'b0;
      r_id_err     <= 1'b0;
      r_lcd_rgb_oe <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_scnt  <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (r_scnt == '0) begin
            r_ref      <= w_p;
            r_mismatch <= 1'b0;
          end else if (w_p != r_ref) begin
            r_mismatch <= 1'b1;
          end
          if (r_scnt == SMP_LAST) begin
            r_scnt  <= '0;
            r_state <= ST_EVAL;
          end else begin
            r_scnt <= r_scnt + SW'(1);
          end
        end
        ST_EVAL: begin
          if (!r_mismatch) begin
            r_id_lcd     <= 16'(r_ref);
            r_id_err     <= 1'b0;
            r_id_valid   <= 1'b1;
            r_lcd_rgb_oe <= 1'b1;
            r_state      <= ST_DONE;
          end else if (r_retry < RETRY_LAST) begin
            r_retry    <= r_retry + RW'(1);
            r_mismatch <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_SETTLE;
          end else begin
            r_id_lcd     <= DEFAULT_ID;
            r_id_err     <= 1'b1;
            r_id_valid   <= 1'b1;
            r_lcd_rgb_oe <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.i_redetect) begin
            r_id_valid   <= 1'b0;
            r_lcd_rgb_oe <= 1'b0;
            r_retry      <= '0;
            r_cnt        <= '0;
            r_id_err     <= 1'b0;
            r_mismatch   <= 1'b0;
            r_state      <= ST_SETTLE;
          end
        end
        default: begin
          r_state <= ST_SETTLE;
        end
      endcase
    end
  end

  assign bus.o_id_lcd     = r_id_lcd;
  assign bus.o_id_valid   = r_id_valid;
  assign bus.o_id_err     = r_id_err;
  assign bus.o_lcd_rgb_oe = r_lcd_rgb_oe;

endmodule

// File: tb/tb_lcd_id_detect.sv
// Testbench for lcd_id_detect (sync option off).
// Each phase pre-computes a per-cycle strap plan, a reference model derives from the plan
// which attempt (if any) sees SAMPLES agreeing values and when id_valid must rise, and the
// bench checks all outputs after every clock edge against that expectation.
module tb_lcd_id_detect;

  localparam int          RGB_W      = 24;
  localparam int          ID_BITS    = 3;
  localparam int          SETTLE_CYC = 16;
  localparam int          SAMPLES    = 4;
  localparam int          MAX_RETRY  = 3;
  localparam logic [15:0] DEFAULT_ID = 16'd5;
  localparam int          ATTEMPT    = SETTLE_CYC + SAMPLES + 1;
  localparam int          NCYC       = ATTEMPT * (MAX_RETRY + 1) + 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lcd_id_detect_if #(.RGB_W(RGB_W)) bus ();

  lcd_id_detect #(
    .RGB_W      (RGB_W),
    .ID_BITS    (ID_BITS),
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLES    (SAMPLES),
    .MAX_RETRY  (MAX_RETRY),
    .DEFAULT_ID (DEFAULT_ID)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ID_BITS-1:0] plan [NCYC];
  int                 expT;
  logic [15:0]        expId;
  logic               expErr;
  logic [15:0]        lastId;

  function automatic logic [RGB_W-1:0] toRgb(input logic [ID_BITS-1:0] p);
    logic [RGB_W-1:0] w;
    w = RGB_W'($urandom);
    for (int k = 0; k < ID_BITS; k++) w[8*k+7] = p[k];
    return w;
  endfunction

  // mode 0 static, 1 bit0 toggles in first window only, 2 bit0 toggles always, 3 random glitches
  task automatic buildPlan(input int mode, input logic [ID_BITS-1:0] strap);
    for (int i = 0; i < NCYC; i++) begin
      plan[i] = strap;
      case (mode)
        1: if (i >= SETTLE_CYC && i < SETTLE_CYC + SAMPLES) plan[i] = strap ^ ID_BITS'(i & 1);
        2: plan[i] = strap ^ ID_BITS'(i & 1);
        3: if ($urandom_range(0, 5) == 0) plan[i] = strap ^ ID_BITS'(1 << $urandom_range(0, ID_BITS-1));
        default: ;
      endcase
    end
  endtask

  // Attempt a samples straps on edges a*ATTEMPT+SETTLE_CYC+1 .. +SAMPLES; first agreeing one wins
  task automatic computeModel();
    bit found;
    found  = 0;
    expId  = DEFAULT_ID;
    expErr = 1'b1;
    expT   = ATTEMPT * (MAX_RETRY + 1);
    for (int a = 0; a <= MAX_RETRY; a++) begin
      int  base;
      bit  agree;
      base  = a * ATTEMPT + SETTLE_CYC;
      agree = 1;
      for (int j = 1; j < SAMPLES; j++) if (plan[base+j] != plan[base]) agree = 0;
      if (agree && !found) begin
        found  = 1;
        expId  = 16'(plan[base]);
        expErr = 1'b0;
        expT   = (a + 1) * ATTEMPT;
      end
    end
  endtask

  // Called at a negedge when the next posedge is the first settle cycle
  task automatic runPhase(input string name, input logic [15:0] prevId, input int ignoreAt, input int lastN);
    logic        wantValid;
    logic [15:0] wantId;
    logic        wantErr;
    for (int n = 1; n <= lastN; n++) begin
      bus.i_lcd_rgb_in = toRgb(plan[n-1]);
      bus.i_redetect   = (n == ignoreAt);
      @(posedge clk);
      #1;
      wantValid = (n >= expT);
      wantId    = wantValid ? expId : prevId;
      wantErr   = wantValid ? expErr : 1'b0;
      total += 4;
      if (bus.o_id_valid !== wantValid) begin
        bad++;
        $display("[TB] FAIL %s id_valid edge=%0d got=%b want=%b", name, n, bus.o_id_valid, wantValid);
      end
      if (bus.o_lcd_rgb_oe !== wantValid) begin
        bad++;
        $display("[TB] FAIL %s lcd_rgb_oe edge=%0d got=%b want=%b", name, n, bus.o_lcd_rgb_oe, wantValid);
      end
      if (bus.o_id_lcd !== wantId) begin
        bad++;
        $display("[TB] FAIL %s id_lcd edge=%0d got=%h want=%h", name, n, bus.o_id_lcd, wantId);
      end
      if (bus.o_id_err !== wantErr) begin
        bad++;
        $display("[TB] FAIL %s id_err edge=%0d got=%b want=%b", name, n, bus.o_id_err, wantErr);
      end
      @(negedge clk);
    end
    bus.i_redetect = 1'b0;
  endtask

  task automatic startFromReset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.i_redetect = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // From DONE: one-cycle redetect; outputs drop valid/oe/err, id_lcd holds
  task automatic pulseRedetect(input string name, input logic [15:0] prevId);
    bus.i_redetect = 1'b1;
    @(posedge clk);
    #1;
    total += 4;
    if (bus.o_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s id_valid got=%b want=0", name, bus.o_id_valid); end
    if (bus.o_lcd_rgb_oe !== 1'b0) begin bad++; $display("[TB] FAIL %s lcd_rgb_oe got=%b want=0", name, bus.o_lcd_rgb_oe); end
    if (bus.o_id_lcd !== prevId) begin bad++; $display("[TB] FAIL %s id_lcd got=%h want=%h", name, bus.o_id_lcd, prevId); end
    if (bus.o_id_err !== 1'b0) begin bad++; $display("[TB] FAIL %s id_err got=%b want=0", name, bus.o_id_err); end
    @(negedge clk);
    bus.i_redetect = 1'b0;
  endtask

  task automatic checkResetValues(input string name);
    total += 4;
    if (bus.o_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s id_valid got=%b want=0", name, bus.o_id_valid); end
    if (bus.o_lcd_rgb_oe !== 1'b0) begin bad++; $display("[TB] FAIL %s lcd_rgb_oe got=%b want=0", name, bus.o_lcd_rgb_oe); end
    if (bus.o_id_lcd !== DEFAULT_ID) begin bad++; $display("[TB] FAIL %s id_lcd got=%h want=%h", name, bus.o_id_lcd, DEFAULT_ID); end
    if (bus.o_id_err !== 1'b0) begin bad++; $display("[TB] FAIL %s id_err got=%b want=0", name, bus.o_id_err); end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.i_redetect   = 1'b0;
    bus.i_lcd_rgb_in = toRgb(3'b111);
    repeat (3) @(negedge clk);
    checkResetValues("reset");
  endtask

  task automatic test_clean_detect();
    buildPlan(0, 3'b101);
    computeModel();
    startFromReset();
    runPhase("clean_101", DEFAULT_ID, 0, NCYC);
    buildPlan(0, 3'b110);
    computeModel();
    startFromReset();
    runPhase("clean_110", DEFAULT_ID, 0, NCYC);
    lastId = expId;
  endtask

  task automatic test_retry();
    buildPlan(1, 3'b011);
    computeModel();
    startFromReset();
    runPhase("retry", DEFAULT_ID, 0, NCYC);
    lastId = expId;
  endtask

  task automatic test_all_fail();
    buildPlan(2, ID_BITS'($urandom));
    computeModel();
    startFromReset();
    runPhase("all_fail", DEFAULT_ID, 0, NCYC);
    lastId = expId;
  endtask

  task automatic test_redetect();
    pulseRedetect("redetect_pulse", lastId);
    buildPlan(0, 3'b010);
    computeModel();
    runPhase("redetect", lastId, 0, NCYC);
    lastId = expId;
  endtask

  task automatic test_redetect_ignored();
    buildPlan(0, ID_BITS'($urandom));
    computeModel();
    startFromReset();
    runPhase("ignored_settle", DEFAULT_ID, $urandom_range(1, SETTLE_CYC), NCYC);
    buildPlan(3, ID_BITS'($urandom));
    computeModel();
    startFromReset();
    runPhase("ignored_sample", DEFAULT_ID, $urandom_range(SETTLE_CYC + 1, ATTEMPT), NCYC);
    lastId = expId;
  endtask

  task automatic test_reset_mid_sample();
    logic [15:0] held;
    held = lastId;
    pulseRedetect("mid_pulse", held);
    buildPlan(0, ~held[ID_BITS-1:0]);
    computeModel();
    runPhase("mid_pre", held, 0, SETTLE_CYC + 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_reset");
    buildPlan(3, ID_BITS'($urandom));
    computeModel();
    @(negedge clk);
    rst_n = 1'b1;
    runPhase("mid_restart", DEFAULT_ID, 0, NCYC);
    lastId = expId;
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 5; it++) begin
      logic [15:0] prev;
      prev = lastId;
      pulseRedetect("b2b_pulse", prev);
      buildPlan($urandom_range(0, 3), ID_BITS'($urandom));
      computeModel();
      runPhase("b2b", prev, $urandom_range(0, ATTEMPT), NCYC);
      lastId = expId;
    end
  endtask

  initial begin
    bus.i_lcd_rgb_in = '0;
    bus.i_redetect   = 1'b0;
    lastId           = DEFAULT_ID;
    test_reset();
    test_clean_detect();
    test_retry();
    test_all_fail();
    test_redetect();
    test_redetect_ignored();
    test_reset_mid_sample();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
